// File: rtl/int_to_float_if.sv
// int_to_float_if
//   Handshake/data bundle between an integer producer and the int_to_float
//   converter. The float side matches float_ops, so out_result can be wired
//   straight into a float_ops operand.
//
//   Handshake: the producer raises in_start with in_int/in_signed valid; the
//   converter samples them only while idle. out_ready rises once out_result
//   is valid and both stay stable until in_start is seen low; out_ready
//   drops on that edge. The producer must not rely on in_int after accept.
//
//   Signals
//     in_start    producer -> converter  request a conversion
//     in_signed   producer -> converter  1 = in_int is two's complement
//     in_int      producer -> converter  integer operand (INT_BITS)
//     out_ready   converter -> producer  result valid
//     out_result  converter -> producer  converted float (BITS)
interface int_to_float_if #(
   parameter int BITS     = 32,
   parameter int INT_BITS = 32
);
   logic                in_start;
   logic                in_signed;
   logic [INT_BITS-1:0] in_int;
   logic                out_ready;
   logic [BITS-1:0]     out_result;

   modport master (
      output in_start,
      output in_signed,
      output in_int,
      input  out_ready,
      input  out_result
   );

   modport slave (
      input  in_start,
      input  in_signed,
      input  in_int,
      output out_ready,
      output out_result
   );
endinterface

// File: rtl/int_to_float.sv
// int_to_float
//   Serial integer -> IEEE-754-style float converter. The operand is latched
//   on an accepted start, normalised one left shift per clock, then rounded
//   to nearest (ties to even) in a single ROUND cycle. Results too large for
//   the exponent field become signed infinity. Subnormals cannot occur.
//
//   Ports
//     in_clk     clock, all state changes on the rising edge
//     in_rst     asynchronous active-high reset
//     bus        int_to_float_if.slave (in_start, in_signed, in_int,
//                out_ready, out_result)
//     dbg_state  current FSM state (IDLE=0, NORMALISE=1, ROUND=2, READY=3)
//
//   Latency: counting the accepting edge as edge 1, out_ready rises after
//   edge lz+3 (lz = leading zeros of the magnitude), or after edge 1 for 0.
module int_to_float #(
   parameter int BITS     = 32,
   parameter int EXP_BITS = 8,
   parameter int INT_BITS = 32
) (
   input  logic              in_clk,
   input  logic              in_rst,
   int_to_float_if.slave     bus,
   output logic [1:0]        dbg_state
);

   localparam int MANT_BITS = BITS - 1 - EXP_BITS;
   localparam int BIAS      = (1 << (EXP_BITS - 1)) - 1;
   // Exponent counter must hold INT_BITS-1 + bias + 1 and the all-ones
   // exponent value without wrapping; two spare bits cover both.
   localparam int EW_BASE   = (EXP_BITS > $clog2(INT_BITS + 2)) ? EXP_BITS
                                                                : $clog2(INT_BITS + 2);
   localparam int EW        = EW_BASE + 2;

   localparam logic [EW-1:0] EXP_START = EW'(INT_BITS - 1);
   localparam logic [EW-1:0] BIAS_W    = EW'(BIAS);
   localparam logic [EW-1:0] EXP_MAX   = EW'((1 << EXP_BITS) - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_NORMALISE = 2'd1,
      S_ROUND     = 2'd2,
      S_READY     = 2'd3
   } state_t;

   state_t              state_q, state_n;
   logic                sign_q, sign_n;
   logic [INT_BITS-1:0] mag_q, mag_n;
   logic [EW-1:0]       exp_q, exp_n;
   logic                ready_q, ready_n;
   logic [BITS-1:0]     result_q, result_n;

   // Operand capture values, only used in IDLE
   logic                in_sign;
   logic [INT_BITS-1:0] in_mag;

   // Rounding datapath, only used in ROUND. The hidden bit (mag_q MSB) is
   // implicit, so the frame holds the bits below it followed by zero padding
   // that covers mantissa + guard even when INT_BITS-1 < MANT_BITS.
   logic [INT_BITS+MANT_BITS:0] frame;
   logic [MANT_BITS-1:0]        mant;
   logic                        guard;
   logic                        sticky;
   logic                        round_up;
   logic [MANT_BITS:0]          mant_sum;
   logic [EW-1:0]               exp_adj;
   logic [EW-1:0]               biased;

   assign dbg_state = state_q;

   assign bus.out_ready  = ready_q;
   assign bus.out_result = result_q;

   assign in_sign = bus.in_signed & bus.in_int[INT_BITS-1];
   // Negating -2^(INT_BITS-1) wraps to itself, which read as unsigned is
   // exactly the wanted magnitude.
   assign in_mag  = in_sign ? -bus.in_int : bus.in_int;

   assign frame    = {mag_q[INT_BITS-2:0], {(MANT_BITS + 2){1'b0}}};
   assign mant     = frame[INT_BITS+MANT_BITS:INT_BITS+1];
   assign guard    = frame[INT_BITS];
   assign sticky   = |frame[INT_BITS-1:0];
   assign round_up = guard & (sticky | mant[0]);
   assign mant_sum = {1'b0, mant} + {{MANT_BITS{1'b0}}, round_up};
   // A carry out of the mantissa leaves mant_sum's low bits all zero, which
   // is already the correct mantissa for the bumped exponent.
   assign exp_adj  = exp_q + {{(EW-1){1'b0}}, mant_sum[MANT_BITS]};
   assign biased   = exp_adj + BIAS_W;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         exp_q    <= '0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_n;
         sign_q   <= sign_n;
         mag_q    <= mag_n;
         exp_q    <= exp_n;
         ready_q  <= ready_n;
         result_q <= result_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      sign_n   = sign_q;
      mag_n    = mag_q;
      exp_n    = exp_q;
      ready_n  = ready_q;
      result_n = result_q;

      unique case (state_q)
         S_IDLE: begin
            ready_n = 1'b0;
            if (bus.in_start) begin
               sign_n = in_sign;
               mag_n  = in_mag;
               exp_n  = EXP_START;
               if (in_mag == '0) begin
                  // Zero skips normalisation and is always +0
                  result_n = '0;
                  ready_n  = 1'b1;
                  state_n  = S_READY;
               end else begin
                  state_n = S_NORMALISE;
               end
            end
         end

         S_NORMALISE: begin
            if (mag_q[INT_BITS-1]) begin
               state_n = S_ROUND;
            end else begin
               mag_n = {mag_q[INT_BITS-2:0], 1'b0};
               exp_n = exp_q - {{(EW-1){1'b0}}, 1'b1};
            end
         end

         S_ROUND: begin
            if (biased >= EXP_MAX) begin
               result_n = {sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
            end else begin
               result_n = {sign_q, biased[EXP_BITS-1:0], mant_sum[MANT_BITS-1:0]};
            end
            ready_n = 1'b1;
            state_n = S_READY;
         end

         S_READY: begin
            // Held until the requester lets go of in_start, so a level-held
            // start cannot retrigger a second conversion.
            if (!bus.in_start) begin
               ready_n = 1'b0;
               state_n = S_IDLE;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float
//   Bench for int_to_float: a 32-bit (8-bit exponent) instance and a 16-bit
//   (5-bit exponent) instance, both with 32-bit integer input. Directed
//   vectors with known results, then random operands checked against an
//   arithmetic reference model. Latency, hold behaviour, asynchronous reset
//   and operand isolation during conversion are also checked.
module tb_int_to_float;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sgn = 1'b0;
   logic [31:0] ival = '0;
   logic       sel16 = 1'b0;

   int n_checks = 0;
   int n_fails  = 0;

   int_to_float_if #(.BITS(32), .INT_BITS(32)) bus32 ();
   int_to_float_if #(.BITS(16), .INT_BITS(32)) bus16 ();

   logic [1:0] dbg32, dbg16;

   int_to_float #(.BITS(32), .EXP_BITS(8), .INT_BITS(32)) dut32 (
      .in_clk    (clk),
      .in_rst    (rst),
      .bus       (bus32),
      .dbg_state (dbg32)
   );

   int_to_float #(.BITS(16), .EXP_BITS(5), .INT_BITS(32)) dut16 (
      .in_clk    (clk),
      .in_rst    (rst),
      .bus       (bus16),
      .dbg_state (dbg16)
   );

   assign bus32.in_start  = start & ~sel16;
   assign bus16.in_start  = start & sel16;
   assign bus32.in_signed = sgn;
   assign bus16.in_signed = sgn;
   assign bus32.in_int    = ival;
   assign bus16.in_int    = ival;

   logic        ready;
   logic [31:0] result;
   assign ready  = sel16 ? bus16.out_ready : bus32.out_ready;
   assign result = sel16 ? {16'h0, bus16.out_result} : bus32.out_result;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic longint unsigned magnitude(input logic s, input logic [31:0] v);
      if (s && v[31]) return 64'h1_0000_0000 - {32'h0, v};
      return {32'h0, v};
   endfunction

   function automatic int msb_pos(input longint unsigned m);
      int p = -1;
      for (int i = 0; i < 33; i++) if (((m >> i) & 64'd1) != 0) p = i;
      return p;
   endfunction

   // Value-level conversion: scale, round to nearest-even using the exact
   // remainder, renormalise on overflow, saturate to infinity.
   function automatic logic [31:0] model(input int bits, input int ebits,
                                         input logic s, input logic [31:0] v);
      longint unsigned mag, q, rem, half, res;
      int e, m, bias, sh;
      bit neg;
      m    = bits - 1 - ebits;
      bias = (1 << (ebits - 1)) - 1;
      neg  = s && v[31];
      mag  = magnitude(s, v);
      if (mag == 0) return 32'h0;
      e = msb_pos(mag);
      if (e > m) begin
         sh   = e - m;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << (m + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
      end else begin
         q = mag << (m - e);
      end
      res = neg ? (64'd1 << (bits - 1)) : 64'd0;
      if (e + bias >= (1 << ebits) - 1)
         res = res | (((64'd1 << ebits) - 1) << m);
      else
         res = res | (longint'(e + bias) << m) | (q & ((64'd1 << m) - 1));
      return res[31:0];
   endfunction

   function automatic int expected_latency(input logic s, input logic [31:0] v);
      longint unsigned mag;
      mag = magnitude(s, v);
      if (mag == 0) return 1;
      return (31 - msb_pos(mag)) + 3;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Runs one conversion. perturb > 0 rewrites in_int/in_signed right after
   // that edge, while the converter is busy.
   task automatic convert(input bit w16, input logic s, input logic [31:0] v,
                          input logic [31:0] exp_res, input string tag,
                          input int perturb);
      int edges;
      int lat;
      lat = expected_latency(s, v);
      @(negedge clk);
      sel16 = w16;
      sgn   = s;
      ival  = v;
      start = 1'b1;
      check({tag, " idle_ready"}, {31'h0, ready}, 32'h0);
      edges = 0;
      do begin
         @(posedge clk);
         edges++;
         #1;
         if (perturb > 0 && edges == perturb) begin
            ival = 32'd7;
            sgn  = ~s;
         end
      end while (!ready && edges < 100);
      check({tag, " ready"}, {31'h0, ready}, 32'h1);
      check({tag, " latency"}, edges, lat);
      check({tag, " result"}, result, exp_res);
      repeat (2) begin
         @(posedge clk);
         #1;
         check({tag, " hold_ready"}, {31'h0, ready}, 32'h1);
         check({tag, " hold_result"}, result, exp_res);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " drop_ready"}, {31'h0, ready}, 32'h0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      logic [31:0] v;
      logic        s;

      // Reset state
      #1;
      check("rst ready32", {31'h0, bus32.out_ready}, 32'h0);
      check("rst result32", bus32.out_result, 32'h0);
      check("rst ready16", {31'h0, bus16.out_ready}, 32'h0);
      check("rst result16", {16'h0, bus16.out_result}, 32'h0);
      check("rst state32", {30'h0, dbg32}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed 32-bit
      convert(1'b0, 1'b1, 32'd1,         32'h3f800000, "one", 0);
      convert(1'b0, 1'b1, -32'sd5,       32'hc0a00000, "neg5", 0);
      convert(1'b0, 1'b1, 32'd0,         32'h00000000, "zero", 0);
      convert(1'b0, 1'b1, 32'h80000000,  32'hcf000000, "minint", 0);
      convert(1'b0, 1'b0, 32'h80000000,  32'h4f000000, "u_2p31", 0);
      convert(1'b0, 1'b0, 32'h01000001,  32'h4b800000, "tie_even", 0);
      convert(1'b0, 1'b0, 32'h01000003,  32'h4b800002, "tie_up", 0);
      convert(1'b0, 1'b0, 32'h7fffffff,  32'h4f000000, "carry", 0);

      // Directed 16-bit
      convert(1'b1, 1'b0, 32'd100,       32'h00005640, "h100", 0);
      convert(1'b1, 1'b0, 32'd65504,     32'h00007bff, "hmax", 0);
      convert(1'b1, 1'b0, 32'd70000,     32'h00007c00, "hinf", 0);
      convert(1'b1, 1'b1, -32'sd70000,   32'h0000fc00, "hneginf", 0);

      // Asynchronous reset mid-conversion (previous result is nonzero)
      @(negedge clk);
      sel16 = 1'b0;
      sgn   = 1'b1;
      ival  = 32'd1;
      start = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort ready", {31'h0, bus32.out_ready}, 32'h0);
      check("abort result", bus32.out_result, 32'h0);
      check("abort state", {30'h0, dbg32}, 32'h0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("post_abort idle", {30'h0, dbg32}, 32'h0);
      convert(1'b0, 1'b1, 32'd3, 32'h40400000, "restart3", 0);

      // Operand change while normalising is ignored
      convert(1'b0, 1'b0, 32'd3, 32'h40400000, "isolate3", 3);

      // Random 32-bit and 16-bit operands against the model
      for (int i = 0; i < 40; i++) begin
         v = $urandom() >> $urandom_range(0, 31);
         s = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) v = -v;
         convert(1'b0, s, v, model(32, 8, s, v), "rand32", 0);
      end
      for (int i = 0; i < 30; i++) begin
         v = $urandom() >> $urandom_range(8, 31);
         s = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) v = -v;
         convert(1'b1, s, v, model(16, 5, s, v), "rand16", 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
